// File: rtl/sram_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl_pkg
// Brief    : Shared definitions for the MEM-stage to 16-bit SRAM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned C_SRAM_DW             = 16;
  localparam int unsigned C_WORD_DW             = 32;
  localparam int unsigned C_DEFAULT_BASE_ADDR   = 1024;
  localparam int unsigned C_DEFAULT_SRAM_AW     = 18;
  localparam int unsigned C_DEFAULT_WAIT_CYCLES = 1;

  // Counter width able to hold WAIT_CYCLES; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl_if
// Brief    : MEM-stage request bus plus external SRAM pins for sram_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_mem_ctrl_if
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_AW = C_DEFAULT_SRAM_AW
) ();

  logic                 wr_en;
  logic                 rd_en;
  logic [C_WORD_DW-1:0] addr;
  logic [C_WORD_DW-1:0] wdata;
  logic [C_WORD_DW-1:0] rdata;
  logic                 ready;
  logic [SRAM_AW-1:0]   sram_addr;
  logic [C_SRAM_DW-1:0] sram_dq_o;
  logic [C_SRAM_DW-1:0] sram_dq_i;
  logic                 sram_dq_oe;
  logic                 sram_we_n;
  logic                 sram_oe_n;

  // master = pipeline plus SRAM device side, slave = the controller
  modport master (
    output wr_en, rd_en, addr, wdata, sram_dq_i,
    input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata, sram_dq_i,
    output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
  );

endinterface
`default_nettype wire

// File: rtl/sram_mem_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl_phase_timer
// Brief    : Clear/enable phase counter; o_tc flags the last cycle of a phase.
// Revision : 1.0 - initial release
// ============================================================================
module sram_mem_ctrl_phase_timer
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = C_DEFAULT_WAIT_CYCLES
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_tc
);

  localparam int unsigned     C_CW = timer_width(WAIT_CYCLES);
  localparam logic [C_CW-1:0] C_TC = C_CW'(WAIT_CYCLES);

  logic [C_CW-1:0] r_count;

  // Clear wins over enable so the count restarts on the phase boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + C_CW'(1);
    end
  end

  assign o_tc = (r_count == C_TC);

endmodule
`default_nettype wire

// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl
// Brief    : Splits 32-bit LDR/STR into two 16-bit SRAM phases with wait states.
// Revision : 1.0 - initial release
// ============================================================================
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = C_DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW     = C_DEFAULT_SRAM_AW,
  parameter int unsigned WAIT_CYCLES = C_DEFAULT_WAIT_CYCLES
) (
  input wire logic       clk,
  input wire logic       rst,
  sram_mem_ctrl_if.slave bus
);

  state_t               r_state;
  logic                 r_is_write;
  logic [SRAM_AW-2:0]   r_hw_word;
  logic [C_SRAM_DW-1:0] r_wdata_hi;
  logic [C_WORD_DW-1:0] r_rdata;
  logic [SRAM_AW-1:0]   r_sram_addr;
  logic [C_SRAM_DW-1:0] r_dq_o;
  logic                 r_dq_oe;
  logic                 r_we_n;
  logic                 r_oe_n;

  logic                 w_req;
  logic                 w_tc;
  logic                 w_in_phase;
  logic                 w_timer_clr;
  logic [SRAM_AW-2:0]   w_hw_word;

  assign w_req       = bus.wr_en | bus.rd_en;
  assign w_in_phase  = (r_state == ST_LO) || (r_state == ST_HI);
  assign w_timer_clr = ~w_in_phase | w_tc;

  // Word index relative to BASE_ADDR; truncation gives the modulo wrap.
  assign w_hw_word = (SRAM_AW-1)'((bus.addr - BASE_ADDR) >> 2);

  sram_mem_ctrl_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_timer_clr),
    .i_en  (w_in_phase),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_hw_word   <= '0;
      r_wdata_hi  <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            // Write wins when both requests are present.
            r_state     <= ST_LO;
            r_is_write  <= bus.wr_en;
            r_hw_word   <= w_hw_word;
            r_wdata_hi  <= bus.wdata[31:16];
            r_sram_addr <= {w_hw_word, 1'b0};
            r_dq_o      <= bus.wdata[15:0];
            r_dq_oe     <= bus.wr_en;
            r_we_n      <= ~bus.wr_en;
            r_oe_n      <= bus.wr_en;
          end
        end
        ST_LO: begin
          if (w_tc) begin
            r_state     <= ST_HI;
            r_sram_addr <= {r_hw_word, 1'b1};
            r_dq_o      <= r_wdata_hi;
            if (!r_is_write) begin
              r_rdata[15:0] <= bus.sram_dq_i;
            end
          end
        end
        ST_HI: begin
          if (w_tc) begin
            r_state <= ST_DONE;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (!r_is_write) begin
              r_rdata[31:16] <= bus.sram_dq_i;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Idle ready drops as soon as a request appears so the pipeline freezes in the same cycle.
  assign bus.ready      = (r_state == ST_DONE) || ((r_state == ST_IDLE) && !w_req);
  assign bus.rdata      = r_rdata;
  assign bus.sram_addr  = r_sram_addr;
  assign bus.sram_dq_o  = r_dq_o;
  assign bus.sram_dq_oe = r_dq_oe;
  assign bus.sram_we_n  = r_we_n;
  assign bus.sram_oe_n  = r_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_mem_ctrl
// Brief    : Random + directed bench for sram_mem_ctrl (WAIT_CYCLES 1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_mem_ctrl;
  import sram_mem_ctrl_pkg::*;

  localparam int unsigned C_AW    = 18;
  localparam int unsigned C_WORDS = 32'h20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr_en, rd_en;
  logic [31:0] addr, wdata;
  int          n_vec = 0;
  int          n_err = 0;

  bit   [15:0] mem1 [0:(1<<C_AW)-1];
  bit   [15:0] mem0 [0:(1<<C_AW)-1];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rdata [2];

  always #5 clk = ~clk;

  sram_mem_ctrl_if #(.SRAM_AW(C_AW)) bus1 ();
  sram_mem_ctrl_if #(.SRAM_AW(C_AW)) bus0 ();

  assign bus1.wr_en     = wr_en & ~sel;
  assign bus1.rd_en     = rd_en & ~sel;
  assign bus1.addr      = addr;
  assign bus1.wdata     = wdata;
  assign bus1.sram_dq_i = bus1.sram_oe_n ? 16'hDEAD : mem1[bus1.sram_addr];
  assign bus0.wr_en     = wr_en & sel;
  assign bus0.rd_en     = rd_en & sel;
  assign bus0.addr      = addr;
  assign bus0.wdata     = wdata;
  assign bus0.sram_dq_i = bus0.sram_oe_n ? 16'hDEAD : mem0[bus0.sram_addr];

  always @(posedge clk) if (!bus1.sram_we_n) mem1[bus1.sram_addr] <= bus1.sram_dq_o;
  always @(posedge clk) if (!bus0.sram_we_n) mem0[bus0.sram_addr] <= bus0.sram_dq_o;

  sram_mem_ctrl #(.BASE_ADDR(1024), .SRAM_AW(C_AW), .WAIT_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  sram_mem_ctrl #(.BASE_ADDR(1024), .SRAM_AW(C_AW), .WAIT_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  logic        w_ready, w_we_n, w_oe_n, w_dq_oe;
  logic [31:0] w_rdata;
  assign w_ready = sel ? bus0.ready      : bus1.ready;
  assign w_we_n  = sel ? bus0.sram_we_n  : bus1.sram_we_n;
  assign w_oe_n  = sel ? bus0.sram_oe_n  : bus1.sram_oe_n;
  assign w_dq_oe = sel ? bus0.sram_dq_oe : bus1.sram_dq_oe;
  assign w_rdata = sel ? bus0.rdata      : bus1.rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model key: one word space of 2^17 words per DUT.
  function automatic int unsigned ref_key(input logic s, input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (s ? C_WORDS : 32'd0) + ((off >> 2) % C_WORDS);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned key);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  function automatic logic [31:0] sram_word(input logic s, input int unsigned key);
    int unsigned hw;
    hw = (key % C_WORDS) * 2;
    return s ? {mem0[hw+1], mem0[hw]} : {mem1[hw+1], mem1[hw]};
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit drop, input string tag);
    int          lat, n_we, n_oe, exp_lat;
    int unsigned key;
    bit          clash;
    exp_lat = sel ? 3 : 5;
    key     = ref_key(sel, a);
    @(negedge clk);
    wr_en = wr; rd_en = rd; addr = a; wdata = d;
    #1 check_eq({tag, "_rdy0"}, 32'(w_ready), 32'h0);
    lat = 0; n_we = 0; n_oe = 0; clash = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (drop && lat == 1) begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
      if (!w_we_n) n_we++;
      if (!w_oe_n) n_oe++;
      if ((w_dq_oe && !w_oe_n) || (!w_we_n && !w_oe_n)) clash = 1'b1;
    end while (!w_ready && lat < 20);
    check_eq({tag, "_lat"},   32'(lat),   32'(exp_lat));
    check_eq({tag, "_we"},    32'(n_we),  wr ? 32'(exp_lat - 1) : 32'h0);
    check_eq({tag, "_oe"},    32'(n_oe),  (!wr && rd) ? 32'(exp_lat - 1) : 32'h0);
    check_eq({tag, "_clash"}, 32'(clash), 32'h0);
    if (wr) begin
      ref_mem[key] = d;
      check_eq({tag, "_sram"}, sram_word(sel, key), d);
    end else if (rd) begin
      ref_rdata[sel] = ref_rd(key);
    end
    check_eq({tag, "_rdata"}, w_rdata, ref_rdata[sel]);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, tmp;
    int unsigned kind, idx, op;
    sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", bus1.rdata, 32'h0);
    check_eq("rst_addr",  32'(bus1.sram_addr), 32'h0);
    check_eq("rst_strb",  32'({bus1.sram_we_n, bus1.sram_oe_n, bus1.sram_dq_oe}), 32'h6);
    rst = 1'b0;

    // Idle: ready high, strobes released
    repeat (10) begin
      @(negedge clk);
      check_eq("idle", 32'({bus1.ready, bus1.sram_we_n, bus1.sram_oe_n, bus1.sram_dq_oe}), 32'hE);
    end

    access(1'b1, 1'b0, 32'd1024, 32'h0000_2000, 1'b0, "t2_str");
    check_eq("t2_hw0", 32'(mem1[0]), 32'h2000);
    check_eq("t2_hw1", 32'(mem1[1]), 32'h0000);

    access(1'b1, 1'b0, 32'd1028, 32'hC000_0000, 1'b0, "t3_str");
    access(1'b0, 1'b1, 32'd1028, 32'h0,         1'b0, "t3_ldr");
    check_eq("t3_hw3",   32'(mem1[3]), 32'hC000);
    check_eq("t3_rdata", bus1.rdata,   32'hC000_0000);

    access(1'b1, 1'b1, 32'd1032, 32'h8000_0000, 1'b0, "t4_both");
    check_eq("t4_rdata", bus1.rdata, 32'hC000_0000);
    check_eq("t4_hw5",   32'(mem1[5]), 32'h8000);

    // Reset pulse in the first HI cycle of a write
    @(negedge clk);
    wr_en = 1'b1; addr = 32'd1036; wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 check_eq("t5_hi_addr", 32'(bus1.sram_addr), 32'd7);
    rst = 1'b1;
    #1 check_eq("t5_strb", 32'({bus1.sram_we_n, bus1.sram_oe_n, bus1.sram_dq_oe}), 32'h6);
    wr_en = 1'b0;
    #1 check_eq("t5_ready", 32'(bus1.ready), 32'h1);
    check_eq("t5_rdata", bus1.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tmp = ref_rd(32'd3);
    ref_mem[32'd3] = {tmp[31:16], 16'h5678};
    ref_rdata[0] = '0;
    check_eq("t5_hw6", 32'(mem1[6]), 32'h5678);
    check_eq("t5_hw7", 32'(mem1[7]), 32'h0000);

    // Random mix of loads/stores, collisions, wrap-around and early drop
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      op   = $urandom_range(0, 2);
      a    = 32'd1024 + 4 * idx + $urandom_range(0, 3);
      if (kind == 0) a = a + 32'h0008_0000;
      if (kind == 1) a = 32'd1024 - 4 * (idx + 1) + $urandom_range(0, 3);
      access(op != 1, op != 0, a, $urandom, $urandom_range(0, 3) == 0, "rnd");
    end

    // Zero wait states
    sel = 1'b1;
    access(1'b1, 1'b0, 32'd1024, 32'h0000_2000, 1'b0, "t6_str");
    access(1'b0, 1'b1, 32'd1024, 32'h0,         1'b0, "t6_ldr");
    check_eq("t6_rdata", bus0.rdata, 32'h0000_2000);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
